// File: rtl/motor_sequencer_pkg.sv
// Shared types, widths and the throttle slew helper for the motor sequencer.
package motor_sequencer_pkg;

    localparam int THR_W   = 8;
    localparam int NUM_MOT = 4;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_FLY      = 2'd2,
        ST_FAILSAFE = 2'd3
    } seq_state_e;

    // One slew step of value toward target, limited to +/-step.
    // The 9-bit signed difference keeps the result bounded by target,
    // so it can never wrap past 0 or 255.
    function automatic logic [THR_W-1:0] slew_next(
        input logic [THR_W-1:0] value,
        input logic [THR_W-1:0] target,
        input logic [THR_W-1:0] step
    );
        logic signed [THR_W:0] diff;
        logic signed [THR_W:0] stp;
        diff = $signed({1'b0, target}) - $signed({1'b0, value});
        stp  = $signed({1'b0, step});
        if (diff > stp)
            return value + step;
        else if (diff < -stp)
            return value - step;
        else
            return target;
    endfunction

endpackage

// File: rtl/motor_sequencer_if.sv
// Flight-control side commands and motor_controller side drive signals.
interface motor_sequencer_if;
    import motor_sequencer_pkg::*;

    logic             arm_req;
    logic             disarm_req;
    logic             cmd_valid;
    logic [31:0]      cmd_throttle;

    logic             mc_reset;
    logic             mc_start;
    logic             mc_idle;
    logic [THR_W-1:0] throttle1;
    logic [THR_W-1:0] throttle2;
    logic [THR_W-1:0] throttle3;
    logic [THR_W-1:0] throttle4;
    logic [1:0]       seq_state;
    logic             failsafe;

    modport master (
        output arm_req, disarm_req, cmd_valid, cmd_throttle,
        input  mc_reset, mc_start, mc_idle, throttle1, throttle2, throttle3, throttle4,
               seq_state, failsafe
    );

    modport slave (
        input  arm_req, disarm_req, cmd_valid, cmd_throttle,
        output mc_reset, mc_start, mc_idle, throttle1, throttle2, throttle3, throttle4,
               seq_state, failsafe
    );

endinterface

// File: rtl/motor_sequencer_throttle_slew.sv
// One throttle channel: registered value that steps toward its target on each tick.
module motor_sequencer_throttle_slew
    import motor_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             clear,
    input  logic [THR_W-1:0] target,
    input  logic [THR_W-1:0] step,
    output logic [THR_W-1:0] value
);

    logic [THR_W-1:0] value_q, value_d;

    // Clear (disarm) beats the slew step so the motor drops to zero at once.
    always_comb begin
        value_d = value_q;
        if (clear)
            value_d = '0;
        else if (tick)
            value_d = slew_next(value_q, target, step);
    end

    // Value register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/motor_sequencer.sv
// Motor sequencer: arming, slew-limited throttle tracking, command watchdog
// with failsafe ramp-down, and disarm through the motor_controller reset.
module motor_sequencer
    import motor_sequencer_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int ARM_TICKS  = 2000,
    parameter int SLEW_STEP  = 4,
    parameter int WDOG_TICKS = 100
) (
    input  logic              clock,
    input  logic              reset_n,
    motor_sequencer_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int AW = $clog2(ARM_TICKS + 1);
    localparam int WW = $clog2(WDOG_TICKS + 1);

    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0]    ARM_LAST  = AW'(ARM_TICKS - 1);
    localparam logic [WW-1:0]    WDOG_LAST = WW'(WDOG_TICKS - 1);
    localparam logic [THR_W-1:0] STEP      = THR_W'(SLEW_STEP);

    seq_state_e                        state_q, state_d;
    logic [PW-1:0]                     presc_q, presc_d;
    logic [AW-1:0]                     arm_cnt_q, arm_cnt_d;
    logic [WW-1:0]                     wdog_q, wdog_d;
    // Lane 3 is motor 1 (cmd_throttle[31:24]) down to lane 0 = motor 4.
    logic [NUM_MOT-1:0][THR_W-1:0]     target_q, target_d;
    logic [NUM_MOT-1:0][THR_W-1:0]     thr;
    logic                              failsafe_q, failsafe_d;
    logic                              mc_reset_q, mc_reset_d;
    logic                              mc_start_q, mc_start_d;
    logic                              mc_idle_q, mc_idle_d;

    logic tick, arm_ok, wdog_exp, slew_en, slew_clr;

    assign tick     = (presc_q == PRESC_MAX);
    assign arm_ok   = (state_q == ST_DISARMED) && bus.arm_req && !bus.disarm_req && (target_q == '0);
    assign wdog_exp = (state_q == ST_FLY) && tick && !bus.cmd_valid && (wdog_q == WDOG_LAST);
    assign slew_en  = tick && ((state_q == ST_FLY) || (state_q == ST_FAILSAFE));
    assign slew_clr = (state_d == ST_DISARMED);

    // Next state, counters, targets and registered output drive.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        failsafe_d = failsafe_q;

        if (bus.disarm_req) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: if (arm_ok) begin
                    state_d    = ST_ARMING;
                    failsafe_d = 1'b0;
                end
                ST_ARMING: if (tick) begin
                    if (arm_cnt_q == ARM_LAST) state_d = ST_FLY;
                    else                       arm_cnt_d = arm_cnt_q + AW'(1);
                end
                ST_FLY: if (wdog_exp) begin
                    state_d    = ST_FAILSAFE;
                    failsafe_d = 1'b1;
                end
                ST_FAILSAFE: if (thr == '0) state_d = ST_DISARMED;
                default: state_d = ST_DISARMED;
            endcase
        end
        if (state_q != ST_ARMING) arm_cnt_d = '0;

        // Watchdog only runs in FLY; a command always wins over a same-cycle expiry.
        wdog_d = wdog_q;
        if (state_q != ST_FLY || bus.cmd_valid) wdog_d = '0;
        else if (tick)                          wdog_d = wdog_q + WW'(1);

        // Prescaler restarts on every state change so each phase is tick-aligned.
        presc_d = (state_d != state_q || tick) ? '0 : presc_q + PW'(1);

        target_d = target_q;
        if (state_d == ST_FAILSAFE) target_d = '0;
        else if (bus.cmd_valid)     target_d = bus.cmd_throttle;

        mc_reset_d = (state_d == ST_DISARMED);
        mc_start_d = (state_d == ST_ARMING) && (state_q != ST_ARMING);
        mc_idle_d  = (state_d == ST_DISARMED) || (state_d == ST_ARMING);
    end

    // State and control registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_DISARMED;
            presc_q    <= '0;
            arm_cnt_q  <= '0;
            wdog_q     <= '0;
            target_q   <= '0;
            failsafe_q <= 1'b0;
            mc_reset_q <= 1'b1;
            mc_start_q <= 1'b0;
            mc_idle_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            arm_cnt_q  <= arm_cnt_d;
            wdog_q     <= wdog_d;
            target_q   <= target_d;
            failsafe_q <= failsafe_d;
            mc_reset_q <= mc_reset_d;
            mc_start_q <= mc_start_d;
            mc_idle_q  <= mc_idle_d;
        end
    end

    for (genvar i = 0; i < NUM_MOT; i++) begin : g_lane
        motor_sequencer_throttle_slew u_throttle_slew (
            .clock   (clock),
            .reset_n (reset_n),
            .tick    (slew_en),
            .clear   (slew_clr),
            .target  (target_q[i]),
            .step    (STEP),
            .value   (thr[i])
        );
    end

    assign bus.mc_reset  = mc_reset_q;
    assign bus.mc_start  = mc_start_q;
    assign bus.mc_idle   = mc_idle_q;
    assign bus.throttle1 = thr[3];
    assign bus.throttle2 = thr[2];
    assign bus.throttle3 = thr[1];
    assign bus.throttle4 = thr[0];
    assign bus.seq_state = state_q;
    assign bus.failsafe  = failsafe_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with TICK_DIV=4, ARM_TICKS=3, SLEW_STEP=4, WDOG_TICKS=5.
module tb_motor_sequencer;

    logic clock;
    logic reset_n;
    int   errors;
    int   checks;

    motor_sequencer_if bus ();

    motor_sequencer #(
        .TICK_DIV   (4),
        .ARM_TICKS  (3),
        .SLEW_STEP  (4),
        .WDOG_TICKS (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] thr_all();
        return {bus.throttle1, bus.throttle2, bus.throttle3, bus.throttle4};
    endfunction

    // Advance n clocks, landing 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.arm_req = 1'b0; bus.disarm_req = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_throttle = 32'h0;
        step(3);
        checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.seq_state); end
        checks++; if (bus.mc_reset !== 1'b1) begin errors++; $display("FAIL reset_mc_reset got %b want 1", bus.mc_reset); end
        checks++; if (bus.mc_start !== 1'b0) begin errors++; $display("FAIL reset_mc_start got %b want 0", bus.mc_start); end
        checks++; if (bus.mc_idle !== 1'b1) begin errors++; $display("FAIL reset_mc_idle got %b want 1", bus.mc_idle); end
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL reset_thr got %h want 0", thr_all()); end
        checks++; if (bus.failsafe !== 1'b0) begin errors++; $display("FAIL reset_failsafe got %b want 0", bus.failsafe); end
        reset_n = 1'b1;
    endtask

    task automatic test_arm();
        bus.arm_req = 1'b1;
        step(1);
        bus.arm_req = 1'b0;
        checks++; if (bus.seq_state !== 2'd1) begin errors++; $display("FAIL arm_state got %0d want 1", bus.seq_state); end
        checks++; if (bus.mc_reset !== 1'b0) begin errors++; $display("FAIL arm_mc_reset got %b want 0", bus.mc_reset); end
        checks++; if (bus.mc_start !== 1'b1) begin errors++; $display("FAIL arm_mc_start got %b want 1", bus.mc_start); end
        checks++; if (bus.mc_idle !== 1'b1) begin errors++; $display("FAIL arm_mc_idle got %b want 1", bus.mc_idle); end
        for (int i = 1; i < 12; i++) begin
            step(1);
            checks++; if (bus.seq_state !== 2'd1 || bus.mc_start !== 1'b0 || bus.mc_idle !== 1'b1) begin
                errors++; $display("FAIL arming_hold cyc %0d got state=%0d start=%b idle=%b want 1/0/1",
                                   i, bus.seq_state, bus.mc_start, bus.mc_idle);
            end
        end
        step(1);
        checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL fly_entry got %0d want 2", bus.seq_state); end
        checks++; if (bus.mc_idle !== 1'b0) begin errors++; $display("FAIL fly_idle got %b want 0", bus.mc_idle); end
    endtask

    task automatic test_fly_slew();
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h0A0A0A0A;
        step(1);
        bus.cmd_valid = 1'b0;
        step(2);
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL slew_pre_tick got %h want 0", thr_all()); end
        step(1);
        checks++; if (thr_all() !== 32'h04040404) begin errors++; $display("FAIL slew_up1 got %h want 04040404", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h08080808) begin errors++; $display("FAIL slew_up2 got %h want 08080808", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h0A0A0A0A) begin errors++; $display("FAIL slew_up3 got %h want 0a0a0a0a", thr_all()); end
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h0;
        step(1);
        bus.cmd_valid = 1'b0;
        step(3);
        checks++; if (thr_all() !== 32'h06060606) begin errors++; $display("FAIL slew_dn1 got %h want 06060606", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h02020202) begin errors++; $display("FAIL slew_dn2 got %h want 02020202", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL slew_dn3 got %h want 0", thr_all()); end
        checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL slew_state got %0d want 2", bus.seq_state); end
    endtask

    task automatic test_cmd_on_tick();
        step(3);
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h20202020;
        step(1);
        bus.cmd_valid = 1'b0;
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL tick_old_target got %h want 0", thr_all()); end
        for (int k = 1; k <= 8; k++) begin
            bus.cmd_valid = 1'b1;
            step(1);
            bus.cmd_valid = 1'b0;
            step(3);
            checks++; if (thr_all() !== {4{8'(4 * k)}}) begin
                errors++; $display("FAIL ramp_up k=%0d got %h want %h", k, thr_all(), {4{8'(4 * k)}});
            end
        end
    endtask

    task automatic test_failsafe();
        step(15);
        checks++; if (bus.seq_state !== 2'd2 || bus.failsafe !== 1'b0) begin
            errors++; $display("FAIL wdog_early got state=%0d fs=%b want 2/0", bus.seq_state, bus.failsafe);
        end
        step(1);
        checks++; if (bus.seq_state !== 2'd3 || bus.failsafe !== 1'b1) begin
            errors++; $display("FAIL wdog_expire got state=%0d fs=%b want 3/1", bus.seq_state, bus.failsafe);
        end
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'hFFFFFFFF;
        step(1);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(k == 1 ? 3 : 4);
            checks++; if (thr_all() !== {4{8'(32 - 4 * k)}}) begin
                errors++; $display("FAIL fs_ramp k=%0d got %h want %h", k, thr_all(), {4{8'(32 - 4 * k)}});
            end
        end
        checks++; if (bus.seq_state !== 2'd3 || bus.mc_reset !== 1'b0) begin
            errors++; $display("FAIL fs_at_zero got state=%0d rst=%b want 3/0", bus.seq_state, bus.mc_reset);
        end
        step(1);
        checks++; if (bus.seq_state !== 2'd0 || bus.mc_reset !== 1'b1 || bus.failsafe !== 1'b1) begin
            errors++; $display("FAIL fs_disarmed got state=%0d rst=%b fs=%b want 0/1/1",
                               bus.seq_state, bus.mc_reset, bus.failsafe);
        end
    endtask

    task automatic test_arm_refused();
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h00001000;
        step(1);
        bus.cmd_valid = 1'b0;
        bus.arm_req = 1'b1;
        step(2);
        checks++; if (bus.seq_state !== 2'd0 || bus.mc_reset !== 1'b1 || bus.failsafe !== 1'b1) begin
            errors++; $display("FAIL arm_refused got state=%0d rst=%b fs=%b want 0/1/1",
                               bus.seq_state, bus.mc_reset, bus.failsafe);
        end
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h0;
        step(1);
        bus.cmd_valid = 1'b0;
        step(1);
        checks++; if (bus.seq_state !== 2'd1 || bus.failsafe !== 1'b0 || bus.mc_start !== 1'b1) begin
            errors++; $display("FAIL rearm got state=%0d fs=%b start=%b want 1/0/1",
                               bus.seq_state, bus.failsafe, bus.mc_start);
        end
        bus.arm_req = 1'b0;
        step(12);
        checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL rearm_fly got %0d want 2", bus.seq_state); end
    endtask

    task automatic test_disarm();
        for (int k = 1; k <= 32; k++) begin
            bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h80808080;
            step(1);
            bus.cmd_valid = 1'b0;
            step(3);
        end
        checks++; if (thr_all() !== 32'h80808080) begin errors++; $display("FAIL ramp_80 got %h want 80808080", thr_all()); end
        bus.disarm_req = 1'b1;
        step(1);
        bus.disarm_req = 1'b0;
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL disarm_thr got %h want 0", thr_all()); end
        checks++; if (bus.seq_state !== 2'd0 || bus.mc_reset !== 1'b1 || bus.mc_idle !== 1'b1) begin
            errors++; $display("FAIL disarm_ctl got state=%0d rst=%b idle=%b want 0/1/1",
                               bus.seq_state, bus.mc_reset, bus.mc_idle);
        end
    endtask

    task automatic test_lanes_async_reset();
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h0;
        step(1);
        bus.cmd_valid = 1'b0;
        bus.arm_req = 1'b1;
        step(1);
        bus.arm_req = 1'b0;
        step(12);
        checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL lanes_fly got %0d want 2", bus.seq_state); end
        bus.cmd_valid = 1'b1; bus.cmd_throttle = 32'h08031100;
        step(1);
        bus.cmd_valid = 1'b0;
        step(3);
        checks++; if (thr_all() !== 32'h04030400) begin errors++; $display("FAIL lanes1 got %h want 04030400", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h08030800) begin errors++; $display("FAIL lanes2 got %h want 08030800", thr_all()); end
        step(4);
        checks++; if (thr_all() !== 32'h08030C00) begin errors++; $display("FAIL lanes3 got %h want 08030c00", thr_all()); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (thr_all() !== 32'h0) begin errors++; $display("FAIL areset_thr got %h want 0", thr_all()); end
        checks++; if (bus.seq_state !== 2'd0 || bus.mc_reset !== 1'b1 || bus.mc_idle !== 1'b1 ||
                      bus.mc_start !== 1'b0 || bus.failsafe !== 1'b0) begin
            errors++; $display("FAIL areset_ctl got state=%0d rst=%b idle=%b start=%b fs=%b want 0/1/1/0/0",
                               bus.seq_state, bus.mc_reset, bus.mc_idle, bus.mc_start, bus.failsafe);
        end
        step(2);
        reset_n = 1'b1;
        step(2);
        checks++; if (bus.seq_state !== 2'd0 || thr_all() !== 32'h0) begin
            errors++; $display("FAIL post_reset got state=%0d thr=%h want 0/0", bus.seq_state, thr_all());
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_arm();
        test_fly_slew();
        test_cmd_on_tick();
        test_failsafe();
        test_arm_refused();
        test_disarm();
        test_lanes_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
